// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: operation codes and FSM state encoding.
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_SRL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        WB   = 2'b11
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for N cycles after load.
// Present only in builds with ALU_MUL_EN defined.
module mul_iter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod,
    output logic           last
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] acc_reg;
    logic [2*N-1:0] a_sh_reg;
    logic [N-1:0]   b_sh_reg;
    logic [CW-1:0]  cnt_reg;

    // prod is the accumulator as it stands after the current step, so on the
    // last step it already holds the complete product for the caller to capture.
    assign prod = acc_reg + (b_sh_reg[0] ? a_sh_reg : '0);
    assign last = (cnt_reg == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg  <= '0;
            a_sh_reg <= '0;
            b_sh_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            acc_reg  <= '0;
            a_sh_reg <= {{N{1'b0}}, a};
            b_sh_reg <= b;
            cnt_reg  <= CW'(N);
        end else if (cnt_reg != '0) begin
            acc_reg  <= prod;
            a_sh_reg <= a_sh_reg << 1;
            b_sh_reg <= b_sh_reg >> 1;
            cnt_reg  <= cnt_reg - CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage between register-file read and write-back, with start/busy/done handshake.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise op 110 flags an illegal op.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [N-1:0]    srca,
    input  logic [N-1:0]    srcb,
    input  logic [AW-1:0]   dst,
    output logic [N-1:0]    wd3,
    output logic [AW-1:0]   wa3,
    output logic            we3,
    output logic            busy,
    output logic            done,
    output logic            zero,
    output logic            ovf
);

    state_t        state_reg, state_next;
    op_t           op_reg;
    logic [N-1:0]  a_reg, b_reg;
    logic [AW-1:0] dst_reg;
    logic [N-1:0]  wd3_reg;
    logic [AW-1:0] wa3_reg;
    logic          we3_reg, busy_reg, done_reg, zero_reg, ovf_reg;

    logic [N-1:0]  res_next;
    logic          ovf_next;
    logic          accept;
    logic          finish;
    logic          is_mul;

`ifdef ALU_MUL_EN
    logic [2*N-1:0] mul_prod;
    logic           mul_last;

    assign is_mul = (op == OP_MUL);

    mul_iter #(.N(N)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (accept && is_mul),
        .a    (srca),
        .b    (srcb),
        .prod (mul_prod),
        .last (mul_last)
    );

    assign finish = (state_reg == EXEC) || ((state_reg == MUL) && mul_last);
`else
    assign is_mul = 1'b0;
    assign finish = (state_reg == EXEC);
`endif

    assign accept = (state_reg == IDLE) && start;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = is_mul ? MUL : EXEC;
            EXEC: state_next = WB;
`ifdef ALU_MUL_EN
            MUL:  if (mul_last) state_next = WB;
`endif
            WB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Carry and borrow both fall out as bit N of a zero-extended add/subtract.
    always_comb begin
        res_next = '0;
        ovf_next = 1'b0;
        case (op_reg)
            OP_ADD: {ovf_next, res_next} = {1'b0, a_reg} + {1'b0, b_reg};
            OP_SUB: {ovf_next, res_next} = {1'b0, a_reg} - {1'b0, b_reg};
            OP_AND: res_next = a_reg & b_reg;
            OP_OR:  res_next = a_reg | b_reg;
            OP_XOR: res_next = a_reg ^ b_reg;
            OP_SLT: res_next = {{(N-1){1'b0}}, (a_reg < b_reg)};
            OP_SRL: res_next = a_reg >> b_reg[2:0];
`ifdef ALU_MUL_EN
            OP_MUL: begin
                res_next = mul_prod[N-1:0];
                ovf_next = |mul_prod[2*N-1:N];
            end
`else
            OP_MUL: begin
                res_next = '0;
                ovf_next = 1'b1;
            end
`endif
            default: begin
                res_next = '0;
                ovf_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            op_reg    <= OP_ADD;
            a_reg     <= '0;
            b_reg     <= '0;
            dst_reg   <= '0;
            wd3_reg   <= '0;
            wa3_reg   <= '0;
            we3_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            we3_reg   <= 1'b0;
            if (accept) begin
                op_reg   <= op_t'(op);
                a_reg    <= srca;
                b_reg    <= srcb;
                dst_reg  <= dst;
                busy_reg <= 1'b1;
            end
            // Register $0 is hardwired, so its write enable is suppressed here.
            if (finish) begin
                wd3_reg  <= res_next;
                wa3_reg  <= dst_reg;
                zero_reg <= (res_next == '0);
                ovf_reg  <= ovf_next;
                done_reg <= 1'b1;
                we3_reg  <= (dst_reg != '0);
                busy_reg <= 1'b0;
            end
        end
    end

    assign wd3  = wd3_reg;
    assign wa3  = wa3_reg;
    assign we3  = we3_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign zero = zero_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: table-driven ops plus reset, busy and abort sequences.
// Works with and without ALU_MUL_EN.
module tb_alu_exec_unit;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [N-1:0]  srca, srcb;
    logic [AW-1:0] dst;
    logic [N-1:0]  wd3;
    logic [AW-1:0] wa3;
    logic          we3, busy, done, zero, ovf;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.N(N), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .dst   (dst),
        .wd3   (wd3),
        .wa3   (wa3),
        .we3   (we3),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    op;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [AW-1:0] dst;
        logic [N-1:0]  wd3;
        logic          ovf;
        logic          zero;
        logic          we3;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one op, scramble inputs afterwards, then check latency and write-back.
    task automatic run_op(input vec_t v);
        int k;
        int lat;
        lat = (v.op == 3'b110 && MUL_EN) ? 9 : 2;
        @(negedge clk);
        start = 1'b1; op = v.op; srca = v.a; srcb = v.b; dst = v.dst;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); srca = 8'($urandom); srcb = 8'($urandom); dst = 3'($urandom);
        chk("busy_c1", busy, 1);
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, lat);
        chk("wd3", wd3, v.wd3);
        chk("wa3", wa3, v.dst);
        chk("ovf", ovf, v.ovf);
        chk("zero", zero, v.zero);
        chk("we3", we3, v.we3);
        chk("busy_done", busy, 0);
        $display("txn op=%0d a=%h b=%h dst=%0d -> wd3=%h wa3=%0d we3=%0b ovf=%0b zero=%0b lat=%0d",
                 v.op, v.a, v.b, v.dst, wd3, wa3, we3, ovf, zero, k);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("we3_pulse", we3, 0);
        chk("wd3_hold", wd3, v.wd3);
    endtask

    initial begin
        int k;
        logic seen;
        vec_t v;

        vecs[0]  = '{3'b000, 8'hF0, 8'h20, 3'd3, 8'h10, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{3'b001, 8'h05, 8'h05, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'b001, 8'h03, 8'h05, 3'd1, 8'hFE, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{3'b010, 8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{3'b011, 8'hF0, 8'h0F, 3'd4, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{3'b100, 8'hAA, 8'hAA, 3'd6, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{3'b101, 8'h03, 8'h05, 3'd7, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'b101, 8'h80, 8'h01, 3'd7, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{3'b111, 8'h80, 8'h0F, 3'd5, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b000, 8'h7F, 8'h01, 3'd1, 8'h80, 1'b0, 1'b0, 1'b1};
`ifdef ALU_MUL_EN
        vecs[10] = '{3'b110, 8'h0C, 8'h0B, 3'd5, 8'h84, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{3'b110, 8'h20, 8'h10, 3'd5, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{3'b110, 8'h00, 8'hFF, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0};
`else
        vecs[10] = '{3'b110, 8'h03, 8'h04, 3'd2, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{3'b110, 8'hFF, 8'hFF, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{3'b111, 8'hF0, 8'h04, 3'd3, 8'h0F, 1'b0, 1'b0, 1'b1};
`endif

        // Reset with start asserted: nothing may be accepted.
        rst = 1'b0; start = 1'b1; op = 3'b000; srca = 8'h01; srcb = 8'h01; dst = 3'd1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_wd3", wd3, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_we3", we3, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b1; start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("rst_idle_quiet", seen, 0);

        for (int i = 0; i < NV; i++) run_op(vecs[i]);

        // start held high while busy and through the done cycle must be ignored.
        v = MUL_EN ? '{3'b110, 8'h0C, 8'h0B, 3'd5, 8'h84, 1'b0, 1'b0, 1'b1}
                   : '{3'b000, 8'h11, 8'h22, 3'd4, 8'h33, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        start = 1'b1; op = v.op; srca = v.a; srcb = v.b; dst = v.dst;
        @(negedge clk);
        op = 3'b000; srca = 8'h01; srcb = 8'h01; dst = 3'd7;
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("busy_latency", k, MUL_EN ? 9 : 2);
        chk("busy_wd3", wd3, v.wd3);
        chk("busy_wa3", wa3, v.dst);
        $display("txn busy-ignore op=%0d -> wd3=%h wa3=%0d lat=%0d", v.op, wd3, wa3, k);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy || we3) seen = 1'b1;
        end
        chk("busy_no_requeue", seen, 0);

        // Abort mid-operation with reset: no write-back, then a fresh ADD completes.
        @(negedge clk);
        start = 1'b1; op = MUL_EN ? 3'b110 : 3'b000; srca = 8'h0C; srcb = 8'h0B; dst = 3'd6;
        @(negedge clk);
        start = 1'b0;
        if (MUL_EN) begin
            repeat (3) @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || we3 || busy) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_wd3", wd3, 0);
        $display("txn abort op=%0d -> done/we3 suppressed=%0b", MUL_EN ? 6 : 0, !seen);
        v = '{3'b000, 8'h05, 8'h07, 3'd2, 8'h0C, 1'b0, 1'b0, 1'b1};
        run_op(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the 8-entry register file.
- Consumes the two read operands (rd1/rd2), performs the selected operation, and drives the register-file write port (wd3/wa3/we3) for write-back.
- Single-cycle logic ops plus an iterative shift-add multiply; a start/busy/done handshake toward the control FSM.

Parameters:
- N, 8, datapath width (matches register width)
- AW, 3, register address width (8 registers)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  operation code (see Behaviour)
- srca  in  N  operand A (from rd1)
- srcb  in  N  operand B (from rd2)
- dst  in  AW  destination register index
- wd3  out  N  write-back data
- wa3  out  AW  write-back address
- we3  out  1  write-back enable, one-cycle pulse
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- zero  out  1  result == 0, valid with done
- ovf  out  1  carry/borrow/overflow, valid with done

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE; wd3=0, wa3=0, we3=0, busy=0, done=0, zero=0, ovf=0; multiply counter and accumulator cleared. Reset overrides start and aborts any operation in progress, with no write-back.
- Op codes:
  - 000 ADD: ovf = carry out.
  - 001 SUB: A-B; ovf = borrow.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: unsigned; result 1 or 0.
  - 110 MUL: low N bits; ovf = any upper product bit set.
  - 111 SRL: A >> B[2:0].
  - ovf = 0 for AND, OR, XOR, SLT, SRL.
- Operands, op and dst are latched on the accepting edge. Inputs may change afterwards with no effect.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE: start=1 with op!=110 -> EXEC. start=1 with op==110 -> MUL, counter=N, acc=0. busy=1 from the next cycle.
  - EXEC: computes the result -> WB.
  - MUL: each cycle, if B[0] then acc += A (2N-bit); A <<= 1, B >>= 1, counter-1. At counter==1 -> WB after the final step.
  - WB: wd3/wa3/zero/ovf registered; done=1 and we3=(wa3!=0) for exactly one cycle -> IDLE; busy drops to 0 in the same cycle done is high.
- Latency: start edge = cycle 0.
  - Simple ops: done high in cycle 2.
  - MUL: done high in cycle N+1 (9 for N=8).
- dst==0: register $0 is read-only. we3 stays 0, but done, zero and ovf still pulse normally.
- start while busy is ignored (not queued). start in the same cycle as the done pulse is also ignored. The next start is accepted in IDLE.
- wd3/wa3 hold their last value between operations. we3 is 0 outside WB.
- MUL with either operand 0 still takes the full N cycles (fixed latency).

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL state and the multiplier sub-module are present, behaving as above.
- Undefined: op 110 is handled as a single-cycle op with result 0, ovf=1 (illegal-op indication), we3 still gated by dst, done in cycle 2. No MUL state and no multiplier hardware.

Decomposition:
- Package alu_pkg:
  - op_t enum (ADD, SUB, AND, OR, XOR, SLT, MUL, SRL; 3 bits).
  - state_t enum (IDLE, EXEC, MUL, WB).
  - Constant OP_W=3.
- One sub-module, mul_iter:
  - Ports: clk, rst, load, a, b → prod (2N), last.
  - Contains the counter, accumulator and shift registers.
  - Instantiated only under ALU_MUL_EN.

Test Plan:
- Reset then idle: rst=0 for 2 cycles -> all outputs 0, busy=0; start pulsed during reset -> no done.
- ADD: A=8'hF0, B=8'h20, dst=3 -> cycle 2: wd3=8'h10, ovf=1, zero=0, we3=1, wa3=3, done=1 for one cycle.
- SUB to $0: A=8'h05, B=8'h05, dst=0 -> wd3=0, zero=1, ovf=0, done=1, we3 stays 0.
- MUL: A=8'h0C, B=8'h0B, dst=5 -> done in cycle 9, wd3=8'h84, ovf=0. Then A=8'h20, B=8'h10 -> wd3=8'h00, ovf=1, zero=1.
- Busy/abort: MUL started, start with ADD re-asserted at cycles 2–5 -> ignored, MUL result written. Second MUL with rst=0 at cycle 4 -> no we3/done, state IDLE, the next ADD completes in 2 cycles.
- Without ALU_MUL_EN: op=110, A=3, B=4, dst=2 -> cycle 2: wd3=0, ovf=1, we3=1, done=1.
